// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: load/store funct3 and opcode constants, LSU state encoding.
// Pure declarations; no logic, latency or flow control of its own.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_MEM  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for the LSU: store mask/replication, load extraction and misalignment flag.
// Purely combinational, no backpressure; LSU_MISALIGN_TRAP_EN enables the misaligned flag.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] ext_rdata,
    output logic        misaligned
);

    logic [1:0]  sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Offset bits below the access size are dropped so lanes stay inside the word.
        sh = addr_lo;
        case (funct3[1:0])
            2'b01:   sh = {addr_lo[1], 1'b0};
            2'b10:   sh = 2'b00;
            default: sh = addr_lo;
        endcase

        byte_sel = 8'(rdata >> {sh, 3'b000});
        half_sel = sh[1] ? rdata[31:16] : rdata[15:0];

        case (funct3[1:0])
            2'b00: begin
                wdata     = {4{rs2[7:0]}};
                wmask     = 4'b0001 << sh;
                ext_rdata = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wdata     = {2{rs2[15:0]}};
                wmask     = 4'b0011 << sh;
                ext_rdata = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                wdata     = rs2;
                wmask     = 4'b1111;
                ext_rdata = rdata;
            end
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit, one transaction at a time; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// rsp_valid 2 edges after accept (+1 per mem wait), 1 on error; req_ready=0 until response taken.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 30
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              store_q, store_d;
    logic              err_q, err_d;

    logic [2:0]        al_funct3;
    logic [1:0]        al_addr_lo;
    logic [3:0]        al_wmask;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;
    logic              al_misaligned;
    logic              f3_bad;
    logic              illegal;
    logic              in_mem;
    logic              in_resp;

    assign in_mem  = (state_q == LSU_MEM);
    assign in_resp = (state_q == LSU_RESP);

    // One aligner serves both phases: live request in IDLE, latched request afterwards.
    assign al_funct3  = (state_q == LSU_IDLE) ? req_funct3    : funct3_q;
    assign al_addr_lo = (state_q == LSU_IDLE) ? req_addr[1:0] : addr_q[1:0];

    riscv_lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .rs2        (wdata_q),
        .rdata      (mem_rdata),
        .wmask      (al_wmask),
        .wdata      (al_wdata),
        .ext_rdata  (al_rdata),
        .misaligned (al_misaligned)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        store_d  = store_q;
        err_d    = err_q;

        f3_bad  = req_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        illegal = (req_load == req_store) || f3_bad || al_misaligned;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    store_d  = req_store;
                    rdata_d  = 32'b0;
                    err_d    = illegal;
                    state_d  = illegal ? LSU_RESP : LSU_MEM;
                end
            end
            LSU_MEM: begin
                if (mem_ready) begin
                    rdata_d = store_q ? 32'b0 : al_rdata;
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                if (rsp_ready) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= LSU_IDLE;
            addr_q   <= '0;
            funct3_q <= 3'b0;
            wdata_q  <= 32'b0;
            rdata_q  <= 32'b0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            store_q  <= store_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == LSU_IDLE);
    assign rsp_valid = in_resp;
    assign rsp_rdata = in_resp ? rdata_q : 32'b0;
    assign rsp_err   = in_resp & err_q;
    assign mem_valid = in_mem;
    assign mem_we    = in_mem & store_q;
    assign mem_addr  = in_mem ? MEM_AW'(addr_q[ADDR_W-1:2]) : '0;
    assign mem_wmask = (in_mem && store_q) ? al_wmask : 4'b0;
    assign mem_wdata = (in_mem && store_q) ? al_wdata : 32'b0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: vector table of single transactions plus back-pressure and reset sequences.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_we, mem_ready = 1'b0;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_rdata = 32'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.ADDR_W(32), .MEM_AW(30)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        logic [31:0] e_rdata;
        logic [3:0]  e_wmask;
        logic [31:0] e_wdata;
        logic [29:0] e_maddr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int waits, input logic err,
                                input logic [31:0] e_rdata, input logic [3:0] e_wmask,
                                input logic [31:0] e_wdata, input logic [29:0] e_maddr);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.err = err; v.e_rdata = e_rdata; v.e_wmask = e_wmask;
        v.e_wdata = e_wdata; v.e_maddr = e_maddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, " mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, " mem_we"},    32'(mem_we), 32'd0);
        chk({tag, " mem_addr"},  32'(mem_addr), 32'd0);
        chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    endtask

    task automatic clear_req();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        string p;
        p = $sformatf("v%0d", i);
        @(negedge clk);
        chk({p, " req_ready"}, 32'(req_ready), 32'd1);
        drive_req(v.ld, v.st, v.f3, v.addr, v.wdata);
        mem_rdata = v.rdata;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_req();
        if (v.err) begin
            chk({p, " err rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({p, " err rsp_err"},   32'(rsp_err), 32'd1);
            chk({p, " err rsp_rdata"}, rsp_rdata, 32'd0);
            chk({p, " err mem_valid"}, 32'(mem_valid), 32'd0);
            @(negedge clk);
            chk({p, " err rsp_done"},  32'(rsp_valid), 32'd0);
        end else begin
            for (int w = 0; w <= v.waits; w++) begin
                chk({p, " mem_valid"}, 32'(mem_valid), 32'd1);
                chk({p, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
                chk({p, " req_ready busy"}, 32'(req_ready), 32'd0);
                chk({p, " mem_we"}, 32'(mem_we), 32'(v.st));
                chk({p, " mem_addr"}, 32'(mem_addr), 32'(v.e_maddr));
                chk({p, " mem_wmask"}, 32'(mem_wmask), v.st ? 32'(v.e_wmask) : 32'd0);
                if (v.st) chk({p, " mem_wdata"}, mem_wdata, v.e_wdata);
                mem_ready = (w == v.waits);
                @(negedge clk);
            end
            mem_ready = 1'b0;
            chk({p, " rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({p, " rsp_err"},   32'(rsp_err), 32'd0);
            chk({p, " rsp_rdata"}, rsp_rdata, v.e_rdata);
            chk({p, " mem_idle"},  32'(mem_valid), 32'd0);
            @(negedge clk);
            chk({p, " rsp_done"},  32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ld st f3 addr wdata rdata waits err e_rdata e_wmask e_wdata e_maddr
        vt.push_back(mk(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 0, 30'h40));
        vt.push_back(mk(1, 0, 3'b101, 32'h102, 0, 32'hBEEF0000, 3, 0, 32'h0000BEEF, 0, 0, 30'h40));
        vt.push_back(mk(0, 1, 3'b000, 32'h21, 32'h123456AB, 0, 0, 0, 0, 4'b0010, 32'hABABABAB, 30'h8));
        vt.push_back(mk(0, 1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 1, 0, 0, 4'b1111, 32'hDEADBEEF, 30'h8));
`ifdef LSU_MISALIGN_TRAP_EN
        vt.push_back(mk(1, 0, 3'b010, 32'h22, 0, 32'h11223344, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 3'b001, 32'h3, 32'h0000BEEF, 0, 0, 1, 0, 0, 0, 0));
`else
        vt.push_back(mk(1, 0, 3'b010, 32'h22, 0, 32'h11223344, 0, 0, 32'h11223344, 0, 0, 30'h8));
        vt.push_back(mk(0, 1, 3'b001, 32'h3, 32'h0000BEEF, 0, 0, 0, 0, 4'b1100, 32'hBEEFBEEF, 30'h0));
`endif
        vt.push_back(mk(1, 0, 3'b000, 32'h2, 0, 32'h00F50000, 0, 0, 32'hFFFFFFF5, 0, 0, 30'h0));
        vt.push_back(mk(1, 0, 3'b100, 32'h2, 0, 32'h00F50000, 2, 0, 32'h000000F5, 0, 0, 30'h0));
        vt.push_back(mk(1, 0, 3'b001, 32'h6, 0, 32'h80017FFF, 0, 0, 32'hFFFF8001, 0, 0, 30'h1));
        vt.push_back(mk(1, 0, 3'b101, 32'h4, 0, 32'h80017FFF, 1, 0, 32'h00007FFF, 0, 0, 30'h1));
        vt.push_back(mk(0, 1, 3'b001, 32'h6, 32'hAAAA1234, 0, 0, 0, 0, 4'b1100, 32'h12341234, 30'h1));
        vt.push_back(mk(1, 0, 3'b010, 32'hFFFFFFFC, 0, 32'h5A5AA5A5, 0, 0, 32'h5A5AA5A5, 0, 0, 30'h3FFFFFFF));
        vt.push_back(mk(1, 0, 3'b011, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 3'b110, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 3'b000, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 3'b000, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 3'b100, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        resetn = 1'b1;

        foreach (vt[i]) run_vec(vt[i], i);

        // Response back-pressure with a competing request held on the input.
        @(negedge clk);
        drive_req(1, 0, 3'b010, 32'h10, 32'h0);
        mem_rdata = 32'hCAFEF00D;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_req();
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        drive_req(0, 1, 3'b010, 32'h30, 32'h00000055);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rsp_rdata", c), rsp_rdata, 32'hCAFEF00D);
            chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d mem_valid", c), 32'(mem_valid), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp release req_ready", 32'(req_ready), 32'd1);
        chk("bp not yet accepted", 32'(mem_valid), 32'd0);
        @(negedge clk);
        clear_req();
        chk("bp next mem_valid", 32'(mem_valid), 32'd1);
        chk("bp next mem_we", 32'(mem_we), 32'd1);
        chk("bp next mem_addr", 32'(mem_addr), 32'hC);
        chk("bp next mem_wdata", mem_wdata, 32'h00000055);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("bp next rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp next rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);

        // Reset while a transaction waits in MEM, then a late mem_ready.
        drive_req(1, 0, 3'b010, 32'h40, 32'h0);
        @(posedge clk);
        @(negedge clk);
        clear_req();
        chk("rst mem_valid before", 32'(mem_valid), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst mid");
        resetn = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk_reset_vals("rst late ready");
        @(negedge clk);
        chk("rst no rsp", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
